// File: rtl/pipe_stage.sv
// pipe_stage: single-slot valid/ready pipeline register with stall, erase
// and a transfer counter.
// Optional feature macro: PIPE_STAGE_SKID_EN adds a one-entry skid register
// so that in_ready depends only on stored state and the stall input, and not
// on out_ready. Without the macro, in_ready is combinational and the stage
// holds at most one payload.
// Clock is `write`; `reset` is asynchronous and active-high.

module pipe_stage #(
    parameter int unsigned     SIZE        = 32,
    parameter logic [SIZE-1:0] RESET_VALUE = '0,
    parameter int unsigned     CNT_W       = 16
) (
    input  logic             write,
    input  logic             reset,
    input  logic [SIZE-1:0]  in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [SIZE-1:0]  out,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             stall,
    input  logic             erase,
    output logic [CNT_W-1:0] xfer_count
);

    logic            in_fire;
    logic            out_fire;
    logic [SIZE-1:0] out_n;
    logic            out_valid_n;

    // Stall blocks the output handshake here and blocks the input handshake
    // through in_ready.
    assign out_fire = out_valid && out_ready && !stall;
    assign in_fire  = in_valid && in_ready;

    // Count completed output transfers; erase suppresses the transfer it
    // overrides, so that transfer is not counted.
    always_ff @(posedge write or posedge reset) begin
        if (reset) begin
            xfer_count <= '0;
        end else if (out_fire && !erase) begin
            // NOTE: state registers use non-blocking assignment so that every
            // flop samples pre-edge values, independent of block ordering.
            xfer_count <= xfer_count + CNT_W'(1);
        end
    end

`ifdef PIPE_STAGE_SKID_EN

    logic            skid_valid;
    logic [SIZE-1:0] skid;
    logic            skid_valid_n;
    logic [SIZE-1:0] skid_n;

    // in_ready depends only on the skid flop and stall, never on out_ready.
    assign in_ready = !skid_valid && !stall;

    // Next-state for the output slot and the skid entry.
    always_comb begin
        // NOTE: every variable is given its hold value first so that no path
        // through the branches leaves it unassigned and infers a latch.
        out_n        = out;
        out_valid_n  = out_valid;
        skid_n       = skid;
        skid_valid_n = skid_valid;
        if (erase) begin
            out_n        = RESET_VALUE;
            out_valid_n  = 1'b0;
            skid_valid_n = 1'b0;
        end else if (!out_valid || out_fire) begin
            // The output slot frees this cycle: refill from skid first to keep
            // order, else from the input, else go empty.
            if (skid_valid) begin
                out_n        = skid;
                out_valid_n  = 1'b1;
                skid_valid_n = 1'b0;
            end else if (in_fire) begin
                out_n       = in;
                out_valid_n = 1'b1;
            end else begin
                out_valid_n = 1'b0;
            end
        end else if (in_fire) begin
            // Output is held by backpressure: park the new payload.
            skid_n       = in;
            skid_valid_n = 1'b1;
        end
    end

    // Skid entry storage.
    always_ff @(posedge write or posedge reset) begin
        if (reset) begin
            skid       <= RESET_VALUE;
            skid_valid <= 1'b0;
        end else begin
            skid       <= skid_n;
            skid_valid <= skid_valid_n;
        end
    end

`else

    // Accept when not stalled and the slot is empty or draining this cycle.
    assign in_ready = !stall && (!out_valid || out_ready);

    // Next-state for the single output slot.
    always_comb begin
        out_n       = out;
        out_valid_n = out_valid;
        if (erase) begin
            out_n       = RESET_VALUE;
            out_valid_n = 1'b0;
        end else if (in_fire) begin
            out_n       = in;
            out_valid_n = 1'b1;
        end else if (out_fire) begin
            out_valid_n = 1'b0;
        end
    end

`endif

    // Output slot register.
    always_ff @(posedge write or posedge reset) begin
        if (reset) begin
            out       <= RESET_VALUE;
            out_valid <= 1'b0;
        end else begin
            out       <= out_n;
            out_valid <= out_valid_n;
        end
    end

endmodule

// File: tb/tb_pipe_stage.sv
// Directed testbench for pipe_stage. Two instances share all inputs: the
// main one (CNT_W=16) and a narrow-counter one (CNT_W=2) for the wrap test.
// Expectations follow the build selected by PIPE_STAGE_SKID_EN.

module tb_pipe_stage;

    localparam logic [7:0] RV = 8'hA5;

    logic        write = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  din = '0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        stall = 1'b0;
    logic        erase = 1'b0;

    logic        rdy1, vld1;
    logic [7:0]  dout1;
    logic [15:0] cnt1;
    logic        rdy2, vld2;
    logic [7:0]  dout2;
    logic [1:0]  cnt2;

    int n_checks = 0;
    int n_pass   = 0;

    pipe_stage #(.SIZE(8), .RESET_VALUE(RV), .CNT_W(16)) dut (
        .write(write), .reset(reset), .in(din), .in_valid(in_valid),
        .in_ready(rdy1), .out(dout1), .out_valid(vld1), .out_ready(out_ready),
        .stall(stall), .erase(erase), .xfer_count(cnt1)
    );

    pipe_stage #(.SIZE(8), .RESET_VALUE(RV), .CNT_W(2)) dut_w2 (
        .write(write), .reset(reset), .in(din), .in_valid(in_valid),
        .in_ready(rdy2), .out(dout2), .out_valid(vld2), .out_ready(out_ready),
        .stall(stall), .erase(erase), .xfer_count(cnt2)
    );

    always #5 write = ~write;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge write);
        #1;
    endtask

    initial begin
        logic [1:0] wrap_exp [5];
        wrap_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        // Reset state, visible before any clock edge.
        #1 reset = 1'b1;
        #1;
        check("rst_out", 32'(dout1), 32'(RV));
        check("rst_valid", 32'(vld1), 0);
        check("rst_count", 32'(cnt1), 0);
        tick();
        reset = 1'b0;
        #1;
        check("rst_in_ready", 32'(rdy1), 1);

        // Streaming 1..8 at full throughput.
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            din = 8'(i);
            in_valid = 1'b1;
            #1;
            check("stream_ready", 32'(rdy1), 1);
            tick();
            check("stream_out", 32'(dout1), 32'(i));
            check("stream_valid", 32'(vld1), 1);
            check("stream_count", 32'(cnt1), 32'(i - 1));
        end
        in_valid = 1'b0;
        tick();
        check("stream_drain_valid", 32'(vld1), 0);
        check("stream_count_final", 32'(cnt1), 8);

        // Backpressure: A, B, C with out_ready low for three cycles.
        out_ready = 1'b0;
        din = 8'h0A;
        in_valid = 1'b1;
        #1;
        check("bp_ready_c1", 32'(rdy1), 1);
        tick();
        check("bp_out_c1", 32'(dout1), 32'h0A);
        din = 8'h0B;
        #1;
`ifdef PIPE_STAGE_SKID_EN
        check("bp_ready_c2", 32'(rdy1), 1);
        tick();
        din = 8'h0C;
`else
        check("bp_ready_c2", 32'(rdy1), 0);
        tick();
`endif
        check("bp_out_c2", 32'(dout1), 32'h0A);
        #1;
        check("bp_ready_c3", 32'(rdy1), 0);
        tick();
        check("bp_out_c3", 32'(dout1), 32'h0A);
        check("bp_valid_c3", 32'(vld1), 1);
        out_ready = 1'b1;
        #1;
`ifdef PIPE_STAGE_SKID_EN
        check("bp_ready_release", 32'(rdy1), 0);
`else
        check("bp_ready_release", 32'(rdy1), 1);
`endif
        tick();
        check("bp_out_b", 32'(dout1), 32'h0B);
        din = 8'h0C;
        tick();
        check("bp_out_c", 32'(dout1), 32'h0C);
        check("bp_valid_c", 32'(vld1), 1);
        in_valid = 1'b0;
        tick();
        check("bp_drain_valid", 32'(vld1), 0);
        check("bp_count", 32'(cnt1), 11);

        // Stall holding 0x55 with out_ready high.
        out_ready = 1'b0;
        din = 8'h55;
        in_valid = 1'b1;
        tick();
        din = 8'h66;
        stall = 1'b1;
        out_ready = 1'b1;
        #1;
        check("stall_ready", 32'(rdy1), 0);
        for (int k = 0; k < 2; k++) begin
            tick();
            check("stall_out", 32'(dout1), 32'h55);
            check("stall_valid", 32'(vld1), 1);
            check("stall_count", 32'(cnt1), 11);
            check("stall_ready_hold", 32'(rdy1), 0);
        end
        stall = 1'b0;
        in_valid = 1'b0;
        tick();
        check("stall_release_valid", 32'(vld1), 0);
        check("stall_release_count", 32'(cnt1), 12);

        // Erase together with stall and an offered payload.
        out_ready = 1'b0;
        din = 8'h33;
        in_valid = 1'b1;
        tick();
        check("erase_load", 32'(dout1), 32'h33);
        stall = 1'b1;
        erase = 1'b1;
        din = 8'h77;
        out_ready = 1'b1;
        tick();
        check("erase_valid", 32'(vld1), 0);
        check("erase_out", 32'(dout1), 32'(RV));
        check("erase_count", 32'(cnt1), 12);
        stall = 1'b0;
        erase = 1'b0;
        in_valid = 1'b0;
        tick();
        check("erase_dropped", 32'(vld1), 0);
        check("erase_count_after", 32'(cnt1), 12);

        // Erase overriding a concurrent output and input transfer.
        out_ready = 1'b0;
        din = 8'h44;
        in_valid = 1'b1;
        tick();
        erase = 1'b1;
        din = 8'h88;
        out_ready = 1'b1;
        tick();
        check("erase2_valid", 32'(vld1), 0);
        check("erase2_out", 32'(dout1), 32'(RV));
        check("erase2_count", 32'(cnt1), 12);
        erase = 1'b0;
        in_valid = 1'b0;
        tick();
        check("erase2_dropped", 32'(vld1), 0);

        // Asynchronous reset mid-cycle with a payload in flight.
        out_ready = 1'b0;
        din = 8'h99;
        in_valid = 1'b1;
        tick();
        check("areset_pre_valid", 32'(vld1), 1);
        out_ready = 1'b1;
        #2 reset = 1'b1;
        #1;
        check("areset_valid", 32'(vld1), 0);
        check("areset_out", 32'(dout1), 32'(RV));
        check("areset_count", 32'(cnt1), 0);
        check("areset_count_w2", 32'(cnt2), 0);
        @(posedge write);
        #2 reset = 1'b0;
        in_valid = 1'b0;
        #1;
        check("areset_ready", 32'(rdy1), 1);
        check("areset_discard_valid", 32'(vld1), 0);
        tick();
        check("areset_discard_after", 32'(vld1), 0);
        check("areset_count_after", 32'(cnt1), 0);

        // Counter wrap on the narrow instance: five transfers.
        out_ready = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            din = 8'(k);
            in_valid = (k <= 5);
            tick();
            if (k <= 5) check("wrap_out", 32'(dout2), 32'(k));
            if (k >= 2) begin
                check("wrap_count_w2", 32'(cnt2), 32'(wrap_exp[k - 2]));
                check("wrap_count_w16", 32'(cnt1), 32'(k - 1));
            end
        end
        check("wrap_final_valid", 32'(vld2), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_stage.md
PIPE_STAGE -- requirements
Module: pipe_stage

Interface
REQ-001 Parameter SIZE, default 32, payload width in bits (1..256).
REQ-002 Parameter RESET_VALUE, default 0, value loaded into the payload register on reset and on erase.
REQ-003 Parameter CNT_W, default 16, width of the transfer counter (2..32).
REQ-004 write  input  1  clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 in  input  SIZE  upstream payload.
REQ-007 in_valid  input  1  upstream offers a payload.
REQ-008 in_ready  output  1  stage accepts a payload this cycle.
REQ-009 out  output  SIZE  payload presented downstream.
REQ-010 out_valid  output  1  `out` holds a valid payload.
REQ-011 out_ready  input  1  downstream accepts the payload this cycle.
REQ-012 stall  input  1  freezes all state and blocks both transfers.
REQ-013 erase  input  1  synchronous flush of all stored payloads.
REQ-014 xfer_count  output  CNT_W  number of completed output transfers, modulo 2^CNT_W.

Function
REQ-015 Input transfer SHALL occur on a rising edge when in_valid && in_ready; output transfer SHALL occur when out_valid && out_ready && !stall.
REQ-016 Accept-to-out_valid latency SHALL be exactly 1 cycle when the stage is empty.
REQ-017 While stall=1 and erase=0: in_ready SHALL be 0; payload, valid, skid and xfer_count SHALL hold; out and out_valid SHALL remain visible unchanged.
REQ-018 erase=1 SHALL, at the next edge, clear out_valid and skid valid, load `out` with RESET_VALUE, and hold xfer_count; erase SHALL override stall and any concurrent transfer, and the payload offered that cycle SHALL be dropped.
REQ-019 On a simultaneous input and output transfer with no skid entry, `out` SHALL take the new payload and out_valid SHALL stay 1 (full throughput, one payload per cycle).
REQ-020 xfer_count SHALL increment by 1 per output transfer and SHALL wrap from 2^CNT_W-1 to 0.
REQ-021 Payload order SHALL be preserved; no payload SHALL be duplicated or lost except as stated in REQ-018.

Reset
REQ-022 Asserting reset SHALL immediately set out = RESET_VALUE, out_valid = 0, skid valid = 0, and xfer_count = 0, independent of write, stall and erase.
REQ-023 After reset deassertion, in_ready SHALL be 1 unless stall=1.
REQ-024 Reset asserted during an in-flight transfer SHALL discard that transfer; no counter update SHALL occur.

Configuration
REQ-025 Macro PIPE_STAGE_SKID_EN selects the ready path.
REQ-026 With PIPE_STAGE_SKID_EN defined:
- A one-entry skid register is added.
- in_ready SHALL be registered: !skid_valid && !stall.
- A payload accepted while `out` is valid and not draining SHALL go to the skid register.
- On the next output transfer, the skid entry SHALL move to `out`.
- Maximum occupancy SHALL be 2.
REQ-027 Without the macro:
- No skid storage.
- in_ready SHALL be combinational: !stall && (!out_valid || out_ready).
- Maximum occupancy SHALL be 1.
REQ-028 Both builds SHALL present identical out/out_valid sequences for any stimulus in which out_ready never drops while out_valid=1.

Verification
REQ-029 Streaming: feed 0x1..0x8 with in_valid=1, out_ready=1 -> out sequence 0x1..0x8 on consecutive cycles, first payload one cycle after acceptance, xfer_count=8.
REQ-030 Backpressure: out_ready=0 for 3 cycles while feeding 0xA,0xB,0xC.
- With SKID_EN: 0xA in out, 0xB in skid, in_ready=0 from the third cycle.
- Without SKID_EN: in_ready=0 after 0xA.
- Releasing out_ready -> 0xA,0xB,0xC in order.
REQ-031 Stall: stall=1 for 2 cycles with out_valid=1, out=0x55, out_ready=1 -> out stays 0x55, no transfer, xfer_count unchanged, in_ready=0.
REQ-032 Erase: erase=1 together with stall=1 and in_valid=1 (in=0x77), stage holding 0x33 -> next cycle out_valid=0, out=RESET_VALUE, 0x77 not delivered, xfer_count unchanged.
REQ-033 Counter wrap: CNT_W=2, 5 output transfers -> xfer_count sequence 1,2,3,0,1.
REQ-034 Async reset: assert reset mid-cycle between write edges with out_valid=1 -> out_valid=0, out=RESET_VALUE, xfer_count=0 before the next edge.
